strobe_checker: RTL and testbench

Receive-side checker for the periodic single-cycle strobe emitted by `strobe_generator`. It measures the interval between strobes and compares it with the expected period and tolerance. It acquires lock after a run of consecutive good periods and reports wrong-period and missing-strobe events. It sits in the consumer clock domain, on the same `clk` as the generator, and feeds status and error counters to the control/status logic.

---
 rtl/strobe_pkg.sv | 14 +
 rtl/strobe_interval_cnt.sv | 32 +++
 rtl/strobe_checker.sv | 152 +++++++++++++++
 tb/tb_strobe_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/strobe_pkg.sv
// Shared types and constants for the strobe checker.
package strobe_pkg;

  // Checker FSM states: no reference, measuring toward lock, locked.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  // Width of the saturating error counter.
  localparam int unsigned ERR_CNT_W = 8;

endpackage : strobe_pkg

// File: rtl/strobe_interval_cnt.sv
// Saturating interval counter: cycles since the last strobe, plus timeout flag.
module strobe_interval_cnt #(
  parameter int unsigned MAX_CNT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_in,
  output logic [CNT_W-1:0] cnt,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] r_cnt;

  // Restart at 1 on a strobe, otherwise count up and hold at saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (strobe_in) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != SAT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A saturated count with no strobe this cycle means the strobe is overdue.
  assign cnt     = r_cnt;
  assign timeout = (r_cnt == SAT) && !strobe_in;

endmodule : strobe_interval_cnt

// File: rtl/strobe_checker.sv
// Periodic strobe checker: measures strobe intervals, tracks lock, flags errors.
module strobe_checker
  import strobe_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = $clog2(EXP_PERIOD + TOL + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strobe_in,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 period_err,
  output logic                 missing_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0]     last_period
);

  localparam int unsigned        MAX_CNT = EXP_PERIOD + TOL + 1;
  localparam int unsigned        GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   P_LO    = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0]   P_HI    = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [GOOD_W-1:0]  GOOD_LK = GOOD_W'(LOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [GOOD_W-1:0]  r_good;
  logic [GOOD_W-1:0]  w_good_nxt;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_timeout;
  logic               w_p_good;
  logic               w_eval;
  logic               w_period_err;
  logic               w_missing_err;

  logic                 r_locked;
  logic                 r_period_err;
  logic                 r_missing_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0]     r_last_period;

  strobe_interval_cnt #(
    .MAX_CNT (MAX_CNT),
    .CNT_W   (CNT_W)
  ) u_interval_cnt (
    .clk       (clk),
    .rst       (rst),
    .strobe_in (strobe_in),
    .cnt       (w_cnt),
    .timeout   (w_timeout)
  );

  // On a strobe cycle the current count is the measured period.
  assign w_p_good = (w_cnt >= P_LO) && (w_cnt <= P_HI);

  // FSM state and consecutive-good-period register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // Next-state, lock progress and error event decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_good_nxt    = r_good;
    w_eval        = 1'b0;
    w_period_err  = 1'b0;
    w_missing_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (strobe_in) begin
          w_state_nxt = S_MEAS;
          w_good_nxt  = '0;
        end
      end
      S_MEAS: begin
        if (strobe_in) begin
          w_eval = 1'b1;
          if (w_p_good) begin
            w_good_nxt = r_good + GOOD_W'(1);
            if (w_good_nxt == GOOD_LK) begin
              w_state_nxt = S_LOCK;
            end
          end else begin
            w_period_err = 1'b1;
            w_good_nxt   = '0;
          end
        end else if (w_timeout) begin
          w_missing_err = 1'b1;
          w_good_nxt    = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      S_LOCK: begin
        if (strobe_in) begin
          w_eval = 1'b1;
          if (!w_p_good) begin
            w_period_err = 1'b1;
            w_good_nxt   = '0;
            w_state_nxt  = S_MEAS;
          end
        end else if (w_timeout) begin
          w_missing_err = 1'b1;
          w_good_nxt    = '0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_good_nxt  = '0;
      end
    endcase
  end

  // Registered status, pulses, saturating error count and last period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked      <= 1'b0;
      r_period_err  <= 1'b0;
      r_missing_err <= 1'b0;
      r_err_cnt     <= '0;
      r_last_period <= '0;
    end else begin
      r_locked      <= (w_state_nxt == S_LOCK);
      r_period_err  <= w_period_err;
      r_missing_err <= w_missing_err;
      if (clr_err) begin
        r_err_cnt <= '0;
      end else if ((w_period_err || w_missing_err) && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
      if (w_eval) begin
        r_last_period <= w_cnt;
      end
    end
  end

  assign locked      = r_locked;
  assign period_err  = r_period_err;
  assign missing_err = r_missing_err;
  assign err_cnt     = r_err_cnt;
  assign last_period = r_last_period;

endmodule : strobe_checker

// File: tb/tb_strobe_checker.sv
// Directed bench for strobe_checker: TOL=0 instance (a) and TOL=1 instance (b).
module tb_strobe_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe_a;
  logic       strobe_b;
  logic       clr_err;

  logic       locked_a, period_err_a, missing_err_a;
  logic [7:0] err_cnt_a;
  logic [2:0] last_period_a;
  logic       locked_b, period_err_b, missing_err_b;
  logic [7:0] err_cnt_b;
  logic [2:0] last_period_b;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned pulses;

  always #5 clk = ~clk;

  strobe_checker #(.EXP_PERIOD(3), .TOL(0), .LOCK_COUNT(4)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .strobe_in   (strobe_a),
    .clr_err     (clr_err),
    .locked      (locked_a),
    .period_err  (period_err_a),
    .missing_err (missing_err_a),
    .err_cnt     (err_cnt_a),
    .last_period (last_period_a)
  );

  strobe_checker #(.EXP_PERIOD(3), .TOL(1), .LOCK_COUNT(4)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .strobe_in   (strobe_b),
    .clr_err     (clr_err),
    .locked      (locked_b),
    .period_err  (period_err_b),
    .missing_err (missing_err_b),
    .err_cnt     (err_cnt_b),
    .last_period (last_period_b)
  );

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs set beforehand are sampled at this edge, outputs read #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic b_strobe_at(input int o);
    return (o == 0) || (o == 2) || (o == 6) || (o == 9) || (o == 13) || (o == 18);
  endfunction

  initial begin
    rst = 1'b1; strobe_a = 1'b0; strobe_b = 1'b0; clr_err = 1'b0;
    tick();
    tick();
    check_val("rst_locked",   locked_a,      0);
    check_val("rst_perr",     period_err_a,  0);
    check_val("rst_merr",     missing_err_a, 0);
    check_val("rst_errcnt",   err_cnt_a,     0);
    check_val("rst_lastp",    last_period_a, 0);
    rst = 1'b0;

    // Period-3 strobes at t=0..12: lock visible after t=12.
    pulses = 0;
    for (int t = 0; t <= 12; t++) begin
      strobe_a = (t % 3 == 0);
      tick();
      if (period_err_a || missing_err_a) pulses++;
      if (t == 9)  check_val("lock_not_yet", locked_a, 0);
      if (t == 12) begin
        check_val("lock_t13",  locked_a,      1);
        check_val("lastp_3",   last_period_a, 3);
      end
    end
    check_val("no_err_pulses_acq", pulses, 0);

    // Late strobe at t=16 (P=4 hits the saturation value): period error, loss of lock.
    for (int t = 13; t <= 16; t++) begin
      strobe_a = (t == 16);
      tick();
      if (t == 15) check_val("no_perr_t16", period_err_a, 0);
    end
    check_val("perr_t17",     period_err_a,  1);
    check_val("merr_t17",     missing_err_a, 0);
    check_val("unlock_t17",   locked_a,      0);
    check_val("errcnt_1",     err_cnt_a,     1);
    check_val("lastp_4",      last_period_a, 4);
    strobe_a = 1'b0;
    tick();
    check_val("perr_single",  period_err_a,  0);

    // Relock with strobes at 19,22,25,28.
    for (int t = 18; t <= 28; t++) begin
      strobe_a = (t % 3 == 1);
      tick();
      if (t == 25) check_val("relock_not_yet", locked_a, 0);
      if (t == 28) check_val("relock",         locked_a, 1);
    end

    // Strobes stop: missing_err only after the cnt==4 cycle (t=32).
    pulses = 0;
    for (int t = 29; t <= 36; t++) begin
      strobe_a = 1'b0;
      tick();
      if (t == 31) begin
        check_val("no_merr_early", missing_err_a, 0);
        check_val("still_locked",  locked_a,      1);
      end
      if (t == 32) begin
        check_val("merr_pulse",    missing_err_a, 1);
        check_val("merr_unlock",   locked_a,      0);
        check_val("errcnt_2",      err_cnt_a,     2);
      end
      if (t > 32 && (missing_err_a || period_err_a)) pulses++;
    end
    check_val("one_merr_per_gap", pulses, 0);

    // Reference strobe from IDLE: not evaluated.
    strobe_a = 1'b1;
    tick();
    check_val("idle_ref_lastp", last_period_a, 3);
    check_val("idle_ref_perr",  period_err_a,  0);

    // Error (P=1) with clr_err in the same cycle: clear wins.
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_val("clr_perr",   period_err_a,  1);
    check_val("clr_wins",   err_cnt_a,     0);
    check_val("lastp_1",    last_period_a, 1);

    // 300 back-to-back bad periods: counter saturates.
    for (int i = 0; i < 300; i++) begin
      strobe_a = 1'b1;
      tick();
      if (i == 254) check_val("errcnt_255_reach", err_cnt_a, 255);
    end
    check_val("errcnt_sat", err_cnt_a, 255);
    strobe_a = 1'b0;
    clr_err  = 1'b1;
    tick();
    clr_err  = 1'b0;
    check_val("errcnt_clr", err_cnt_a, 0);

    // Lock again (first strobe here is P=2, bad), then reset while locked.
    for (int k = 0; k <= 12; k++) begin
      strobe_a = (k % 3 == 0);
      tick();
    end
    check_val("lock_before_rst", locked_a,  1);
    check_val("errcnt_pre_rst",  err_cnt_a, 1);
    strobe_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst2_locked", locked_a,      0);
    check_val("rst2_errcnt", err_cnt_a,     0);
    check_val("rst2_lastp",  last_period_a, 0);
    check_val("rst2_perr",   period_err_a,  0);
    strobe_a = 1'b1;
    tick();
    check_val("post_rst_ref_lastp", last_period_a, 0);
    check_val("post_rst_ref_perr",  period_err_a,  0);
    strobe_a = 1'b0;
    tick();
    tick();
    strobe_a = 1'b1;
    tick();
    strobe_a = 1'b0;
    check_val("post_rst_eval", last_period_a, 3);
    check_val("post_rst_good", period_err_a,  0);

    // TOL=1 instance: periods 2,4,3,4 all good and lock; then 5 is bad.
    for (int o = 0; o <= 18; o++) begin
      strobe_b = b_strobe_at(o);
      tick();
      if (o == 2) begin
        check_val("b_lastp_2", last_period_b, 2);
        check_val("b_p2_good", period_err_b,  0);
      end
      if (o == 9)  check_val("b_lock_not_yet", locked_b, 0);
      if (o == 13) begin
        check_val("b_locked",   locked_b,      1);
        check_val("b_lastp_4",  last_period_b, 4);
        check_val("b_errcnt_0", err_cnt_b,     0);
      end
      if (o == 18) begin
        check_val("b_perr_5",   period_err_b,  1);
        check_val("b_lastp_5",  last_period_b, 5);
        check_val("b_unlock",   locked_b,      0);
        check_val("b_errcnt_1", err_cnt_b,     1);
      end
    end
    strobe_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_strobe_checker
